// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with prefetch FIFO and branch redirect.
// Ports: clk/reset (async, active-high); imemAddr/imemData drive the asynchronous
// instruction memory; brTaken/brTarget redirect fetch; instValid/instReady/instOut/
// instPC present the head FIFO entry to decode; fifoCount reports occupancy.
// Optional macro IMEM_FETCH_HALT_DETECT_EN stops fetch after a HALT_WORD is enqueued.
module imem_fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int DEPTH = 4
`ifdef IMEM_FETCH_HALT_DETECT_EN
  , parameter logic [31:0] HALT_WORD = 32'h0000_0000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic [0:7]  imemAddr,
  input  logic [0:31] imemData,
  input  logic        brTaken,
  input  logic [0:7]  brTarget,
  output logic        instValid,
  input  logic        instReady,
  output logic [0:31] instOut,
  output logic [0:7]  instPC,
  output logic [0:3]  fifoCount
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  logic [7:0] fpc_q, fpc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wa;
  logic [3:0] cnt_q, cnt_d;
  logic [39:0] mem_q [DEPTH];
  logic [39:0] wdat, head_d;
  logic pop, push, we, halted;
  assign imemAddr = brTaken ? brTarget : fpc_q;
  assign instValid = cnt_q != 4'd0;
  assign fifoCount = cnt_q;
  assign pop = instValid & instReady;
  assign push = ~halted & ((cnt_q < DEPTH_C) | pop);
  // A redirect always writes the target word into slot 0, even while halted.
  assign we = brTaken | push;
  assign wa = brTaken ? '0 : wr_q;
  assign wdat = {imemAddr, imemData};
  always_comb begin
    fpc_d = brTaken ? brTarget + 8'd1 : fpc_q + {7'd0, push};
    rd_d = brTaken ? '0 : rd_q + AW'(pop);
    wr_d = brTaken ? AW'(1) : wr_q + AW'(push);
    cnt_d = brTaken ? 4'd1 : cnt_q + {3'd0, push} - {3'd0, pop};
    // The word written this edge becomes the head only when it lands on the new read slot.
    head_d = (we && wa == rd_d) ? wdat : mem_q[rd_d];
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wdat;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      instOut <= '0;
      instPC <= '0;
    end else begin
      fpc_q <= fpc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (cnt_d != 4'd0) begin
        instPC <= head_d[39:32];
        instOut <= head_d[31:0];
      end
    end
  end
`ifdef IMEM_FETCH_HALT_DETECT_EN
  logic halted_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else halted_q <= brTaken ? 1'b0 : halted_q | (push && imemData == HALT_WORD);
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed vector bench for imem_fetch_ctrl.
module tb_imem_fetch_ctrl;
  logic clk = 0, reset = 1, br = 0, rdy = 0;
  logic [7:0] tgt = 0;
  logic [0:7] addr, pc;
  logic [0:31] data, out;
  logic valid;
  logic [0:3] cnt;
  logic [31:0] rom [256];
  int checks = 0, failures = 0;
  typedef struct {
    logic rdy; logic br; logic [7:0] tgt;
    logic ev; logic [7:0] epc; logic [3:0] ecnt;
  } vec_t;
  vec_t vq[$];
  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imemAddr(addr), .imemData(data),
    .brTaken(br), .brTarget(tgt), .instValid(valid), .instReady(rdy),
    .instOut(out), .instPC(pc), .fifoCount(cnt)
  );
  assign data = rom[addr];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    #3 reset = 1;
    #1;
    chk("rst_async_valid", 64'(valid), 0);
    chk("rst_async_cnt", 64'(cnt), 0);
    chk("rst_async_addr", 64'(addr), 0);
    chk("rst_async_pc", 64'(pc), 0);
    #1 reset = 0;
  endtask
  task automatic add(input logic r, input logic b, input logic [7:0] t,
                     input logic ev, input logic [7:0] epc, input logic [3:0] ec);
    vq.push_back('{r, b, t, ev, epc, ec});
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
    add(0, 0, 8'h00, 1, 8'h00, 1);
    add(0, 0, 8'h00, 1, 8'h00, 2);
    add(0, 0, 8'h00, 1, 8'h00, 3);
    add(0, 0, 8'h00, 1, 8'h00, 4);
    add(0, 0, 8'h00, 1, 8'h00, 4);
    add(1, 0, 8'h00, 1, 8'h01, 4);
    add(1, 0, 8'h00, 1, 8'h02, 4);
    add(1, 0, 8'h00, 1, 8'h03, 4);
    add(1, 0, 8'h00, 1, 8'h04, 4);
    add(0, 0, 8'h00, 1, 8'h04, 4);
    add(1, 0, 8'h00, 1, 8'h05, 4);
    add(1, 1, 8'h40, 1, 8'h40, 1);
    add(0, 0, 8'h00, 1, 8'h40, 2);
    add(0, 0, 8'h00, 1, 8'h40, 3);
    add(1, 1, 8'h80, 1, 8'h80, 1);
    add(1, 0, 8'h00, 1, 8'h81, 1);
    add(1, 0, 8'h00, 1, 8'h82, 1);
    add(1, 1, 8'hFE, 1, 8'hFE, 1);
    add(1, 0, 8'h00, 1, 8'hFF, 1);
    add(1, 0, 8'h00, 1, 8'h00, 1);
    add(1, 0, 8'h00, 1, 8'h01, 1);
    add(0, 0, 8'h00, 1, 8'h01, 2);
    add(1, 0, 8'h00, 1, 8'h02, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(valid), 0);
    chk("reset_cnt", 64'(cnt), 0);
    chk("reset_pc", 64'(pc), 0);
    chk("reset_out", 64'(out), 0);
    chk("reset_addr", 64'(addr), 0);
    reset = 0;
    foreach (vq[i]) begin
      rdy = vq[i].rdy; br = vq[i].br; tgt = vq[i].tgt;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(vq[i].ev));
      chk($sformatf("vec%0d_pc", i), 64'(pc), 64'(vq[i].epc));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(vq[i].ecnt));
      chk($sformatf("vec%0d_out", i), 64'(out), 64'(rom[vq[i].epc]));
    end
    br = 0; rdy = 0;
    #1 chk("addr_fpc", 64'(addr), 64'h04);
    br = 1; tgt = 8'h33;
    #1 chk("addr_bypass", 64'(addr), 64'h33);
    br = 0;
    rdy = 1;
    step();
    step();
    pulse_reset();
    step();
    chk("post_rst_valid", 64'(valid), 1);
    chk("post_rst_pc", 64'(pc), 64'h00);
    step();
    chk("post_rst_pc2", 64'(pc), 64'h01);
    chk("post_rst_out2", 64'(out), 64'hA000_0001);
`ifdef IMEM_FETCH_HALT_DETECT_EN
    rom[5] = 32'h0;
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("halt_pc%0d", k), 64'(pc), 64'(k));
      chk($sformatf("halt_valid%0d", k), 64'(valid), 1);
    end
    step();
    chk("halt_empty_valid", 64'(valid), 0);
    chk("halt_empty_cnt", 64'(cnt), 0);
    chk("halt_hold_pc", 64'(pc), 64'h05);
    step();
    chk("halt_stay_valid", 64'(valid), 0);
    chk("halt_fpc", 64'(addr), 64'h06);
    br = 1; tgt = 8'h10;
    step();
    br = 0;
    chk("halt_redir_pc", 64'(pc), 64'h10);
    chk("halt_redir_cnt", 64'(cnt), 1);
    step();
    chk("halt_resume_pc", 64'(pc), 64'h11);
    rom[5] = 32'hA000_0005;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
